// File: rtl/dsa_bilineal_pkg.sv
// Shared types and helpers for the DSA bilinear pixel-memory interface.
package dsa_bilineal_pkg;

    localparam int unsigned PIX_PER_WORD = 4;
    localparam int unsigned PIX_W        = 8;
    localparam int unsigned WORD_W       = 32;

    typedef logic [PIX_W-1:0]  pixel_t;
    typedef logic [WORD_W-1:0] word_t;

    // Memory words occupied by one row of w pixels.
    function automatic int unsigned words_per_line(input int unsigned w);
        return (w + PIX_PER_WORD - 1) / PIX_PER_WORD;
    endfunction

endpackage

// File: rtl/mem_write_controller_if.sv
// Pixel-in / memory-write-out bus of the writer end of the pixel-memory interface.
interface mem_write_controller_if #(
    parameter int unsigned ADDR_W = 10
) ();
    import dsa_bilineal_pkg::*;

    logic              start;
    logic              pix_valid;
    pixel_t            pix_data;
    logic              pix_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    word_t             mem_wdata;
    logic [3:0]        mem_wbe;
    logic              busy;
    logic              done;

    // Writer block side.
    modport slave (
        input  start, pix_valid, pix_data,
        output pix_ready, mem_we, mem_waddr, mem_wdata, mem_wbe, busy, done
    );

    // Pixel source / memory observer side.
    modport master (
        output start, pix_valid, pix_data,
        input  pix_ready, mem_we, mem_waddr, mem_wdata, mem_wbe, busy, done
    );

endinterface

// File: rtl/pixel_packer.sv
// Byte accumulator: packs pixels into a 32-bit word and tracks which bytes are filled.
// The _c outputs show the word/mask including the byte being loaded this cycle.
module pixel_packer
    import dsa_bilineal_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clear,
    input  logic       i_load,
    input  logic       i_complete,
    input  logic [1:0] i_byte_idx,
    input  pixel_t     i_pix,
    output word_t      o_word_c,
    output logic [3:0] o_mask_c
);

    word_t      r_word;
    logic [3:0] r_mask;

    // Merge the incoming byte into the held word.
    always_comb begin
        o_word_c = r_word;
        o_mask_c = r_mask;
        if (i_load) begin
            o_word_c[{i_byte_idx, 3'b000} +: PIX_W] = i_pix;
            o_mask_c[i_byte_idx]                    = 1'b1;
        end
    end

    // Hold partial word; a completed word leaves the buffer empty for the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_mask <= '0;
        end else if (i_clear || (i_load && i_complete)) begin
            r_word <= '0;
            r_mask <= '0;
        end else if (i_load) begin
            r_word <= o_word_c;
            r_mask <= o_mask_c;
        end
    end

endmodule

// File: rtl/mem_write_controller.sv
// Writer end of the DSA pixel-memory interface: packs raster-order 8-bit pixels
// four per 32-bit word and writes them row-major from BASE_ADDR, one frame per start.
// Optional macro MEM_WRITE_BYTE_MASK_EN: partial row-end words carry a byte mask
// covering only valid bytes; otherwise mem_wbe is always 4'hF.
module mem_write_controller
    import dsa_bilineal_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned OUT_WIDTH  = 32,
    parameter int unsigned OUT_HEIGHT = 32,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mem_write_controller_if.slave  bus
);

    localparam int unsigned WPL = words_per_line(OUT_WIDTH);
    localparam int unsigned X_W = (OUT_WIDTH  > 1) ? $clog2(OUT_WIDTH)  : 1;
    localparam int unsigned Y_W = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1;

    localparam longint unsigned MEM_WORDS = 64'd1 << ADDR_W;
    localparam longint unsigned FRAME_END = 64'(BASE_ADDR) + 64'(OUT_HEIGHT) * 64'(WPL);

    // Frame must fit in the addressable memory.
    if (FRAME_END > MEM_WORDS) begin : g_size_check
        $fatal(1, "mem_write_controller: frame exceeds 2**ADDR_W words");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t            r_state,     w_state_nxt;
    logic [X_W-1:0]    r_x,         w_x_nxt;
    logic [Y_W-1:0]    r_y,         w_y_nxt;
    logic              r_pix_ready, w_pix_ready_nxt;
    logic              r_busy,      w_busy_nxt;
    logic              r_done,      w_done_nxt;
    logic              r_mem_we,    w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_waddr, w_mem_waddr_nxt;
    word_t             r_mem_wdata, w_mem_wdata_nxt;
    logic [3:0]        r_mem_wbe,   w_mem_wbe_nxt;

    logic              w_clear;
    logic              w_load;
    logic              w_complete;
    logic              w_row_end;
    logic [1:0]        w_byte_idx;
    word_t             w_word_c;
    logic [3:0]        w_mask_c;

    assign w_byte_idx = 2'(r_x);
    assign w_row_end  = (r_x == X_W'(OUT_WIDTH - 1));
    assign w_complete = (w_byte_idx == 2'd3) || w_row_end;

`ifndef MEM_WRITE_BYTE_MASK_EN
    logic w_unused_mask;
    assign w_unused_mask = ^w_mask_c;
`endif

    pixel_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_clear),
        .i_load     (w_load),
        .i_complete (w_complete),
        .i_byte_idx (w_byte_idx),
        .i_pix      (bus.pix_data),
        .o_word_c   (w_word_c),
        .o_mask_c   (w_mask_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_x_nxt         = r_x;
        w_y_nxt         = r_y;
        w_pix_ready_nxt = r_pix_ready;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_waddr_nxt = r_mem_waddr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_wbe_nxt   = r_mem_wbe;
        w_clear         = 1'b0;
        w_load          = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt     = S_ACCEPT;
                    w_x_nxt         = '0;
                    w_y_nxt         = '0;
                    w_clear         = 1'b1;
                    w_busy_nxt      = 1'b1;
                    w_pix_ready_nxt = 1'b1;
                end
            end
            S_ACCEPT: begin
                if (bus.pix_valid && r_pix_ready) begin
                    w_load = 1'b1;
                    if (w_complete) begin
                        w_mem_we_nxt    = 1'b1;
                        w_mem_waddr_nxt = ADDR_W'(32'(BASE_ADDR) + 32'(r_y) * 32'(WPL)
                                                  + 32'(r_x >> 2));
                        w_mem_wdata_nxt = w_word_c;
`ifdef MEM_WRITE_BYTE_MASK_EN
                        w_mem_wbe_nxt   = w_mask_c;
`else
                        w_mem_wbe_nxt   = 4'hF;
`endif
                    end
                    if (w_row_end) begin
                        w_x_nxt = '0;
                        if (r_y == Y_W'(OUT_HEIGHT - 1)) begin
                            w_state_nxt     = S_FLUSH;
                            w_pix_ready_nxt = 1'b0;
                        end else begin
                            w_y_nxt = r_y + Y_W'(1);
                        end
                    end else begin
                        w_x_nxt = r_x + X_W'(1);
                    end
                end
            end
            S_FLUSH: begin
                w_state_nxt     = S_IDLE;
                w_done_nxt      = 1'b1;
                w_busy_nxt      = 1'b0;
                w_pix_ready_nxt = 1'b0;
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_busy_nxt      = 1'b0;
                w_pix_ready_nxt = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_pix_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_waddr <= '0;
            r_mem_wdata <= '0;
            r_mem_wbe   <= 4'hF;
        end else begin
            r_state     <= w_state_nxt;
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_pix_ready <= w_pix_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_waddr <= w_mem_waddr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_wbe   <= w_mem_wbe_nxt;
        end
    end

    assign bus.pix_ready = r_pix_ready;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_waddr = r_mem_waddr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_wbe   = r_mem_wbe;

endmodule
